mem_stage_ctrl: RTL and testbench

//  MEM-stage controller between EX/MEM and MEM/WB. Runs the data-memory handshake for loads and stores.

---
 rtl/mem_stage_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs the data-memory handshake for loads/stores, stalls
// the front of the pipe while an access is outstanding, and fills the MEM/WB register.
module mem_stage_ctrl #(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 3,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validExMem,
  input  logic              MemReadExMem,
  input  logic              MemWriteExMem,
  input  logic [DATA_W-1:0] AluResExMem,
  input  logic [DATA_W-1:0] RtDataExMem,
  input  logic [REG_AW-1:0] writeRegExMem,
  input  logic              writeRegValidExMem,
  input  logic              forwardC,
  input  logic [DATA_W-1:0] writeDataMemWb,
  output logic              memReq,
  output logic              memWr,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData,
  input  logic              memDone,
  input  logic              memErr,
  output logic              stallMem,
  output logic              validMemWb,
  output logic              MemReadMemWb,
  output logic              writeRegValidMemWb,
  output logic              errMemWb,
  output logic [REG_AW-1:0] writeRegMemWb,
  output logic [DATA_W-1:0] memDataMemWb,
  output logic [DATA_W-1:0] aluResMemWb
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state;
  logic [CW-1:0]     waitCnt;
  logic              pendLoad;
  logic              pendRegValid;
  logic [REG_AW-1:0] pendReg;
  logic              memop;
  logic              timeout;
  logic              finish;

  assign memop   = validExMem & (MemReadExMem | MemWriteExMem);
  assign timeout = (waitCnt == CW'(MAX_WAIT));
  assign finish  = (state == WAIT) & (memDone | timeout);
  // Gated by rst so the stall drops the instant reset asserts, even with a memop pending.
  assign stallMem = rst & (((state == IDLE) & memop) | ((state == WAIT) & ~finish));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      waitCnt            <= '0;
      memReq             <= 1'b0;
      memWr              <= 1'b0;
      memAddr            <= '0;
      memWData           <= '0;
      pendLoad           <= 1'b0;
      pendRegValid       <= 1'b0;
      pendReg            <= '0;
      validMemWb         <= 1'b0;
      MemReadMemWb       <= 1'b0;
      writeRegValidMemWb <= 1'b0;
      errMemWb           <= 1'b0;
      writeRegMemWb      <= '0;
      memDataMemWb       <= '0;
      aluResMemWb        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memop) begin
            state        <= WAIT;
            waitCnt      <= CW'(1);
            memReq       <= 1'b1;
            memWr        <= MemWriteExMem;
            memAddr      <= AluResExMem;
            // Forwarded value is only on writeDataMemWb this cycle, so latch it now.
            memWData     <= forwardC ? writeDataMemWb : RtDataExMem;
            pendLoad     <= MemReadExMem;
            pendRegValid <= writeRegValidExMem;
            pendReg      <= writeRegExMem;
            validMemWb         <= 1'b0;
            MemReadMemWb       <= 1'b0;
            writeRegValidMemWb <= 1'b0;
            errMemWb           <= 1'b0;
            writeRegMemWb      <= '0;
            memDataMemWb       <= '0;
            aluResMemWb        <= '0;
          end else begin
            validMemWb         <= validExMem;
            MemReadMemWb       <= 1'b0;
            writeRegValidMemWb <= validExMem & writeRegValidExMem;
            errMemWb           <= 1'b0;
            writeRegMemWb      <= validExMem ? writeRegExMem : '0;
            memDataMemWb       <= '0;
            aluResMemWb        <= validExMem ? AluResExMem : '0;
          end
        end
        WAIT: begin
          if (finish) begin
            state              <= IDLE;
            waitCnt            <= '0;
            memReq             <= 1'b0;
            memWr              <= 1'b0;
            validMemWb         <= 1'b1;
            MemReadMemWb       <= pendLoad;
            writeRegValidMemWb <= pendRegValid;
            writeRegMemWb      <= pendReg;
            aluResMemWb        <= memAddr;
            // A real completion wins over a coincident timeout.
            errMemWb           <= memDone ? memErr : 1'b1;
            memDataMemWb       <= (memDone & pendLoad) ? memRData : '0;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus a randomized
// instruction stream checked against a per-instruction timing model.
module tb_mem_stage_ctrl;
  localparam int DW = 16;
  localparam int RW = 3;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          validExMem, MemReadExMem, MemWriteExMem;
  logic [DW-1:0] AluResExMem, RtDataExMem, writeDataMemWb, memRData;
  logic [RW-1:0] writeRegExMem;
  logic          writeRegValidExMem, forwardC, memDone, memErr;
  logic          memReq, memWr, stallMem;
  logic [DW-1:0] memAddr, memWData, memDataMemWb, aluResMemWb;
  logic          validMemWb, MemReadMemWb, writeRegValidMemWb, errMemWb;
  logic [RW-1:0] writeRegMemWb;

  int nVec = 0;
  int nErr = 0;

  mem_stage_ctrl #(.DATA_W(DW), .REG_AW(RW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .validExMem(validExMem), .MemReadExMem(MemReadExMem), .MemWriteExMem(MemWriteExMem),
    .AluResExMem(AluResExMem), .RtDataExMem(RtDataExMem), .writeRegExMem(writeRegExMem),
    .writeRegValidExMem(writeRegValidExMem), .forwardC(forwardC), .writeDataMemWb(writeDataMemWb),
    .memReq(memReq), .memWr(memWr), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .memDone(memDone), .memErr(memErr), .stallMem(stallMem),
    .validMemWb(validMemWb), .MemReadMemWb(MemReadMemWb), .writeRegValidMemWb(writeRegValidMemWb),
    .errMemWb(errMemWb), .writeRegMemWb(writeRegMemWb), .memDataMemWb(memDataMemWb),
    .aluResMemWb(aluResMemWb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubbleInputs();
    validExMem = 1'b0; MemReadExMem = 1'b0; MemWriteExMem = 1'b0;
    AluResExMem = '0; RtDataExMem = '0; writeRegExMem = '0; writeRegValidExMem = 1'b0;
    forwardC = 1'b0; writeDataMemWb = '0; memRData = '0; memDone = 1'b0; memErr = 1'b0;
  endtask

  // One memory instruction: doneAt = WAIT cycle carrying memDone (0 or >MW: never).
  task automatic doMemop(input bit isLoad, input logic [DW-1:0] addr, input logic [DW-1:0] rt,
                         input logic [DW-1:0] wb, input logic [DW-1:0] wbNext, input bit fwd,
                         input logic [RW-1:0] wreg, input bit wregV, input int doneAt,
                         input logic [DW-1:0] rdata, input bit err);
    logic [DW-1:0] expWd, expData;
    bit            tmo, expErr;
    int            endK;
    validExMem = 1'b1; MemReadExMem = isLoad; MemWriteExMem = ~isLoad;
    AluResExMem = addr; RtDataExMem = rt; writeRegExMem = wreg; writeRegValidExMem = wregV;
    forwardC = fwd; writeDataMemWb = wb; memDone = 1'b0; memErr = 1'b0;
    tmo     = !(doneAt >= 1 && doneAt <= MW);
    endK    = tmo ? MW : doneAt;
    expWd   = fwd ? wb : rt;
    expErr  = tmo ? 1'b1 : err;
    expData = (!tmo && isLoad) ? rdata : '0;
    #1;
    nVec++;
    if (stallMem !== 1'b1 || memReq !== 1'b0) begin
      nErr++;
      $display("FAIL memop_idle: stall=%b req=%b, want stall=1 req=0", stallMem, memReq);
    end
    tick();
    writeDataMemWb = wbNext;
    forwardC = 1'($urandom);
    for (int k = 1; k <= endK; k++) begin
      if (k == doneAt) begin
        memDone = 1'b1; memErr = err; memRData = rdata;
      end else begin
        memDone = 1'b0; memErr = 1'($urandom); memRData = 16'($urandom);
      end
      #1;
      nVec++;
      if (memReq !== 1'b1 || memWr !== ~isLoad || memAddr !== addr || memWData !== expWd ||
          validMemWb !== 1'b0 || stallMem !== (k != endK)) begin
        nErr++;
        $display("FAIL memop_wait%0d: req=%b wr=%b addr=%h wd=%h vld=%b stall=%b, want 1 %b %h %h 0 %b",
                 k, memReq, memWr, memAddr, memWData, validMemWb, stallMem, ~isLoad, addr, expWd, k != endK);
      end
      tick();
    end
    memDone = 1'b0; memErr = 1'b0;
    nVec++;
    if (memReq !== 1'b0 || validMemWb !== 1'b1 || MemReadMemWb !== isLoad || writeRegMemWb !== wreg ||
        writeRegValidMemWb !== wregV || aluResMemWb !== addr || errMemWb !== expErr ||
        memDataMemWb !== expData) begin
      nErr++;
      $display("FAIL memop_wb: req=%b vld=%b rd=%b reg=%0d rv=%b alu=%h err=%b data=%h, want 0 1 %b %0d %b %h %b %h",
               memReq, validMemWb, MemReadMemWb, writeRegMemWb, writeRegValidMemWb, aluResMemWb, errMemWb,
               memDataMemWb, isLoad, wreg, wregV, addr, expErr, expData);
    end
    bubbleInputs();
  endtask

  // One non-memory instruction (or bubble) with memDone/memErr noise that must be ignored.
  task automatic doAlu(input bit vld, input logic [DW-1:0] res, input logic [RW-1:0] wreg, input bit wregV);
    validExMem = vld; MemReadExMem = 1'b0; MemWriteExMem = 1'b0;
    AluResExMem = res; writeRegExMem = wreg; writeRegValidExMem = wregV;
    memDone = 1'($urandom); memErr = 1'($urandom); memRData = 16'($urandom);
    #1;
    nVec++;
    if (stallMem !== 1'b0 || memReq !== 1'b0) begin
      nErr++;
      $display("FAIL alu_idle: stall=%b req=%b, want 0 0", stallMem, memReq);
    end
    tick();
    nVec++;
    if (validMemWb !== vld || (vld && (aluResMemWb !== res || writeRegMemWb !== wreg ||
        writeRegValidMemWb !== wregV)) || errMemWb !== 1'b0 || memDataMemWb !== '0 ||
        MemReadMemWb !== 1'b0 || memReq !== 1'b0) begin
      nErr++;
      $display("FAIL alu_wb: vld=%b alu=%h reg=%0d rv=%b err=%b data=%h req=%b, want %b %h %0d %b 0 0000 0",
               validMemWb, aluResMemWb, writeRegMemWb, writeRegValidMemWb, errMemWb, memDataMemWb, memReq,
               vld, res, wreg, wregV);
    end
    bubbleInputs();
  endtask

  task automatic test_reset();
    bubbleInputs();
    #2;
    nVec++;
    if (memReq !== 1'b0 || stallMem !== 1'b0 || validMemWb !== 1'b0 || aluResMemWb !== '0) begin
      nErr++;
      $display("FAIL reset_state: req=%b stall=%b vld=%b alu=%h, want all 0", memReq, stallMem, validMemWb, aluResMemWb);
    end
    tick();
    rst = 1'b1;
    tick();
    // Assert reset during the 2nd WAIT cycle of a load.
    validExMem = 1'b1; MemReadExMem = 1'b1; AluResExMem = 16'h0100;
    tick();
    tick();
    rst = 1'b0;
    #1;
    nVec++;
    if (memReq !== 1'b0 || stallMem !== 1'b0 || validMemWb !== 1'b0) begin
      nErr++;
      $display("FAIL reset_midwait: req=%b stall=%b vld=%b, want 0 0 0", memReq, stallMem, validMemWb);
    end
    bubbleInputs();
    tick();
    rst = 1'b1;
    tick();
    doAlu(1'b1, 16'h00AA, 3'd2, 1'b1);
  endtask

  task automatic test_load();
    doMemop(1'b1, 16'h0040, 16'h0, 16'h0, 16'h0, 1'b0, 3'd5, 1'b1, 3, 16'hBEEF, 1'b0);
  endtask

  task automatic test_store_fwd();
    doMemop(1'b0, 16'h0022, 16'h5678, 16'h1234, 16'h0000, 1'b1, 3'd1, 1'b0, 2, 16'h0, 1'b0);
    doMemop(1'b0, 16'h0024, 16'h5678, 16'h1234, 16'h0000, 1'b0, 3'd1, 1'b1, 1, 16'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) doAlu(1'b1, 16'(i), 3'(i), 1'b1);
    doAlu(1'b0, 16'h0, 3'd0, 1'b0);
    doMemop(1'b1, 16'h0010, 16'h0, 16'h0, 16'h0, 1'b0, 3'd3, 1'b1, 1, 16'h1111, 1'b0);
    doMemop(1'b0, 16'h0012, 16'h2222, 16'h0, 16'h0, 1'b0, 3'd0, 1'b0, 2, 16'h0, 1'b0);
  endtask

  task automatic test_timeout();
    doMemop(1'b1, 16'h0080, 16'h0, 16'h0, 16'h0, 1'b0, 3'd6, 1'b1, 0, 16'h0, 1'b0);
    doMemop(1'b0, 16'h0082, 16'h0F0F, 16'h0, 16'h0, 1'b0, 3'd0, 1'b0, MW + 2, 16'h0, 1'b0);
  endtask

  task automatic test_mem_err();
    doMemop(1'b1, 16'h0090, 16'h0, 16'h0, 16'h0, 1'b0, 3'd4, 1'b1, 2, 16'hFFFF, 1'b1);
    doMemop(1'b1, 16'h0092, 16'h0, 16'h0, 16'h0, 1'b0, 3'd4, 1'b1, 2, 16'h3C3C, 1'b0);
    doMemop(1'b1, 16'h0094, 16'h0, 16'h0, 16'h0, 1'b0, 3'd7, 1'b1, MW, 16'hA5A5, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int kind = int'($urandom_range(0, 3));
      if (kind < 2)
        doAlu(kind == 0, 16'($urandom), 3'($urandom), 1'($urandom));
      else
        doMemop(kind == 2, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                3'($urandom), 1'($urandom), int'($urandom_range(0, MW + 2)), 16'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_fwd();
    test_back_to_back();
    test_timeout();
    test_mem_err();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
